adder_bit: RTL and testbench
============================

Name: adder_bit

Overview:
Single-bit full adder with a purely combinational sum/carry path. It adds an optional registered stage for bit-serial addition. In parallel mode it is the ripple-carry building block used by wider adders. In serial mode it keeps its own carry between clock cycles, so it can add two LSB-first bit streams.

Parameters:
CARRY_INIT, 1'b0, value loaded into the internal carry register on reset and on clr.

Ports:
clk  input  1  clock; all registers update on the rising edge.
rst  input  1  asynchronous, active-high reset.
a  input  1  addend bit.
b  input  1  addend bit.
carry_in  input  1  carry input; used only when serial=0.
serial  input  1  0 = parallel (combinational) mode; 1 = bit-serial mode, which uses the internal carry.
en  input  1  register update enable.
clr  input  1  synchronous clear of the internal carry register.
sum  output  1  combinational sum bit.
carry_out  output  1  combinational carry output.
sum_q  output  1  registered sum.
carry_out_q  output  1  registered carry_out.
carry_q  output  1  internal carry register (serial carry state).

Behaviour:
- Effective carry: cin_eff = serial ? carry_q : carry_in.
- Combinational path: {carry_out, sum} = a + b + cin_eff, computed as a 2-bit result.
  - sum = a ^ b ^ cin_eff.
  - carry_out = majority(a, b, cin_eff).
- With serial=0 the path has zero latency and does not depend on clk, rst, en or clr. Outputs settle within one combinational delay of any input change.
- Output sum and carry_out must not go X or Z when all inputs used by the current mode are 0/1.
- Reset (rst=1, asynchronous, effective immediately and for as long as it is held):
  - sum_q=0, carry_out_q=0, carry_q=CARRY_INIT.
  - The combinational outputs keep following their inputs.
  - In serial mode this means they use carry_q=CARRY_INIT.
- On each rising clk edge with rst=0:
  - clr=1: carry_q <= CARRY_INIT. clr has priority over en for carry_q only.
  - en=1 and clr=0: carry_q <= carry_out.
  - en=1, regardless of clr: sum_q <= sum and carry_out_q <= carry_out, taken from the values present just before the edge.
  - en=0: sum_q and carry_out_q hold. carry_q holds unless clr=1.
- carry_q updates in both modes whenever en=1. Switching serial from 0 to 1 therefore continues from the last captured carry; assert clr to start a new serial operation.
- Serial latency: the result bit for stream position k is on sum combinationally during cycle k, and on sum_q one cycle later. The final carry is on carry_q after the last enabled edge.
- Reset asserted mid-serial-operation aborts it; the next operation starts from CARRY_INIT.

Test Plan:
- Parallel exhaustive: serial=0, drive {a,b,carry_in} = 0..7 and check after 1 ns that {carry_out,sum} = a+b+carry_in. Examples: 0,0,0 -> 00; 1,0,1 -> 10; 1,1,1 -> 11. Any mismatch is a failure.
- Reset: with registers nonzero, assert rst without a clock edge -> sum_q=0, carry_out_q=0 and carry_q=CARRY_INIT immediately. Release rst, then one edge with en=1, a=1, b=0, carry_in=0, serial=0 -> sum_q=1, carry_out_q=0.
- Serial add: clr one cycle, then serial=1, en=1; feed 11 (1011) and 6 (0110) LSB-first over 4 cycles. Expected sum per cycle = 1,0,0,0 and carry_q after the 4th edge = 1, giving 17 (10001).
- Enable hold: en=0 while a, b and carry_in toggle over 3 edges -> sum_q, carry_out_q and carry_q unchanged; the combinational sum/carry_out still track the inputs.
- Clear priority: carry_q=1 with clr=1, en=1, a=b=1 -> carry_q becomes CARRY_INIT (0), while sum_q and carry_out_q capture the current sum and carry_out.
- Reset mid-serial: assert rst after 2 of 4 serial bits -> carry_q returns to 0 asynchronously; a subsequent serial 1+1 gives sum=0 and carry_q=1.

Source files
------------

// File: rtl/adder_bit.sv
// Single-bit full adder with a combinational sum/carry path and a registered
// stage that keeps its own carry for LSB-first bit-serial addition.
module adder_bit #(
  parameter logic CARRY_INIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  input  logic carry_in,
  input  logic serial,
  input  logic en,
  input  logic clr,
  output logic sum,
  output logic carry_out,
  output logic sum_q,
  output logic carry_out_q,
  output logic carry_q
);

  logic       cin_eff;
  logic [1:0] total;

  always_comb begin
    cin_eff = serial ? carry_q : carry_in;
    total   = {1'b0, a} + {1'b0, b} + {1'b0, cin_eff};
  end

  assign sum       = total[0];
  assign carry_out = total[1];

  // clr overrides en for the carry state only; sum_q/carry_out_q still capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q       <= 1'b0;
      carry_out_q <= 1'b0;
      carry_q     <= CARRY_INIT;
    end else begin
      if (clr)
        carry_q <= CARRY_INIT;
      else if (en)
        carry_q <= carry_out;
      if (en) begin
        sum_q       <= sum;
        carry_out_q <= carry_out;
      end
    end
  end

endmodule

// File: tb/tb_adder_bit.sv
// Directed bench for adder_bit: vector table for the combinational path plus
// hand-written sequences for reset, serial add, enable hold and clear priority.
module tb_adder_bit;

  logic clk, rst, a, b, carry_in, serial, en, clr;
  logic sum, carry_out, sum_q, carry_out_q, carry_q;

  int checks = 0;
  int errors = 0;

  adder_bit #(.CARRY_INIT(1'b0)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .carry_in(carry_in),
    .serial(serial), .en(en), .clr(clr),
    .sum(sum), .carry_out(carry_out), .sum_q(sum_q),
    .carry_out_q(carry_out_q), .carry_q(carry_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       a;
    logic       b;
    logic       cin;
    logic [1:0] expect_cs;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [1:0] actual, input logic [1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, actual, expected, $time);
    end
  endtask

  // Returns 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic sa [4];
  logic sb [4];
  logic sexp [4];
  logic [1:0] model;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 2'b00};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 2'b01};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 2'b01};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 2'b10};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 2'b01};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 2'b10};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 2'b10};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 2'b11};

    // 11 = 1011, 6 = 0110, LSB first; expected sum bits of 17 = 10001
    sa[0] = 1'b1; sa[1] = 1'b1; sa[2] = 1'b0; sa[3] = 1'b1;
    sb[0] = 1'b0; sb[1] = 1'b1; sb[2] = 1'b1; sb[3] = 1'b0;
    sexp[0] = 1'b1; sexp[1] = 1'b0; sexp[2] = 1'b0; sexp[3] = 1'b0;

    rst = 1'b1; a = 1'b0; b = 1'b0; carry_in = 1'b0;
    serial = 1'b0; en = 1'b0; clr = 1'b0;
    #2;
    check("reset_sum_q", {1'b0, sum_q}, 2'b00);
    check("reset_carry_out_q", {1'b0, carry_out_q}, 2'b00);
    check("reset_carry_q", {1'b0, carry_q}, 2'b00);
    tick();
    rst = 1'b0;

    // Parallel exhaustive while still in reset-free idle (en=0)
    for (int unsigned i = 0; i < 8; i++) begin
      a = vecs[i].a; b = vecs[i].b; carry_in = vecs[i].cin;
      #1;
      check($sformatf("parallel_%0d", i), {carry_out, sum}, vecs[i].expect_cs);
    end

    // Load nonzero registers, then async reset with no edge
    a = 1'b1; b = 1'b1; carry_in = 1'b1; en = 1'b1;
    tick();
    check("load_regs", {sum_q, carry_out_q}, 2'b11);
    check("load_carry_q", {1'b0, carry_q}, 2'b01);
    #1 rst = 1'b1;
    #1;
    check("async_rst_regs", {sum_q, carry_out_q}, 2'b00);
    check("async_rst_carry_q", {1'b0, carry_q}, 2'b00);
    check("rst_comb_follows", {carry_out, sum}, 2'b11);
    #1 rst = 1'b0;
    a = 1'b1; b = 1'b0; carry_in = 1'b0; en = 1'b1;
    tick();
    check("post_rst_capture", {sum_q, carry_out_q}, 2'b10);

    // Serial add 11 + 6
    clr = 1'b1; en = 1'b0;
    tick();
    check("clr_carry_q", {1'b0, carry_q}, 2'b00);
    clr = 1'b0; serial = 1'b1; en = 1'b1; carry_in = 1'b1;
    for (int unsigned k = 0; k < 4; k++) begin
      a = sa[k]; b = sb[k];
      #1;
      check($sformatf("serial_sum_%0d", k), {1'b0, sum}, {1'b0, sexp[k]});
      tick();
      check($sformatf("serial_sum_q_%0d", k), {1'b0, sum_q}, {1'b0, sexp[k]});
    end
    check("serial_final_carry", {1'b0, carry_q}, 2'b01);

    // Enable hold: last edge captured a=1,b=0,cin_eff=1 -> sum_q=0, co_q=1, carry_q=1
    en = 1'b0; serial = 1'b0;
    for (int unsigned k = 0; k < 3; k++) begin
      a = k[0]; b = ~k[0]; carry_in = k[1];
      #1;
      model = {1'b0, a} + {1'b0, b} + {1'b0, carry_in};
      check($sformatf("hold_comb_%0d", k), {carry_out, sum}, model);
      tick();
      check($sformatf("hold_regs_%0d", k), {sum_q, carry_out_q}, 2'b01);
      check($sformatf("hold_carry_q_%0d", k), {1'b0, carry_q}, 2'b01);
    end

    // Clear priority over enable for carry_q only
    serial = 1'b1; a = 1'b1; b = 1'b1; clr = 1'b1; en = 1'b1;
    #1;
    check("clrpri_comb", {carry_out, sum}, 2'b11);
    tick();
    check("clrpri_carry_q", {1'b0, carry_q}, 2'b00);
    check("clrpri_regs", {sum_q, carry_out_q}, 2'b11);
    clr = 1'b0;

    // Reset mid-serial: carry_q is 0 now, feed 1+1 twice
    a = 1'b1; b = 1'b1;
    tick();
    check("mid_bit0_carry_q", {1'b0, carry_q}, 2'b01);
    tick();
    check("mid_bit1_carry_q", {1'b0, carry_q}, 2'b01);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_carry_q", {1'b0, carry_q}, 2'b00);
    check("mid_rst_comb", {carry_out, sum}, 2'b10);
    #1 rst = 1'b0;
    #1;
    check("after_rst_serial_sum", {carry_out, sum}, 2'b10);
    tick();
    check("after_rst_carry_q", {1'b0, carry_q}, 2'b01);
    check("after_rst_regs", {sum_q, carry_out_q}, 2'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
